play_ctrl: RTL and testbench
============================

Name: play_ctrl

Overview:
Player control FSM sitting directly downstream of the button edge-detector stages.
- Consumes their one-cycle pulses (play/pause, next, prev, stop) plus a song-finished pulse from the note sequencer.
- Maintains the current song index and play state.
- Issues a one-cycle start pulse to the sequencer after a fixed silent gap, so song changes are audibly separated.

Parameters:
NUM_SONGS, 4, number of songs; legal range 2..2**IDX_W; need not be a power of two.
IDX_W, 2, width of song_idx.
GAP_CYC, 1000, silent cycles between a song change/start and start_p; legal range 1..2**CNT_W-1.
CNT_W, 10, width of the gap counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
play_p  in  1  one-cycle pulse: play / pause toggle.
next_p  in  1  one-cycle pulse: next song.
prev_p  in  1  one-cycle pulse: previous song.
stop_p  in  1  one-cycle pulse: stop.
song_done  in  1  one-cycle pulse from sequencer: current song ended.
song_idx  out  IDX_W  current song index, registered.
state  out  2  FSM state: STOP=0, GAP=1, PLAY=2, PAUSE=3.
playing  out  1  high iff state==PLAY; sequencer advances notes only while high.
start_p  out  1  registered one-cycle pulse: sequencer restarts song song_idx from note 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=STOP, song_idx=0, gap counter=0, playing=0, start_p=0.
- Reset mid-GAP or mid-PLAY aborts immediately; no start_p is generated.
- Inputs are sampled every rising edge.
- Event priority per cycle: stop_p > next_p > prev_p > song_done > play_p. Only the highest-priority asserted event acts; the others are dropped.
- next: song_idx = (idx==NUM_SONGS-1) ? 0 : idx+1.
- prev: song_idx = (idx==0) ? NUM_SONGS-1 : idx-1.
- "Enter GAP" means: state<=GAP and counter<=GAP_CYC.
- STOP:
  - play_p -> enter GAP.
  - next_p/prev_p -> update idx, stay STOP.
  - song_done and stop_p -> no effect.
- GAP:
  - stop_p -> STOP; counter cleared.
  - next_p/prev_p -> update idx and reload counter (gap restarts).
  - play_p and song_done -> ignored.
  - Otherwise counter decrements. When counter==1 -> state<=PLAY and start_p<=1 on the same edge.
- PLAY:
  - stop_p -> STOP.
  - next_p/prev_p -> update idx, enter GAP.
  - song_done -> song_idx = next index (wrap), enter GAP.
  - play_p -> PAUSE.
- PAUSE:
  - play_p -> PLAY with no start_p (resume mid-song).
  - stop_p -> STOP.
  - next_p/prev_p -> update idx, enter GAP.
  - song_done -> ignored.
- start_p is high for exactly one cycle: the first cycle of PLAY entered from GAP. It is never asserted in any other transition.
- Latency: an event accepted at edge t makes the first cycle in GAP start at t. PLAY and start_p appear GAP_CYC edges later, i.e. after exactly GAP_CYC cycles spent in GAP.
- playing is decoded from registered state (glitch-free). It is low throughout GAP, PAUSE and STOP.
- song_idx never holds a value >= NUM_SONGS.

Optional Feature:
Macro PLAY_CTRL_REPEAT_ONE_EN.
- Defined: song_done in PLAY keeps song_idx unchanged and enters GAP (single-song loop). next_p/prev_p are unaffected.
- Undefined: song_done advances song_idx with wrap, as specified in Behaviour.

Test Plan:
All scenarios use NUM_SONGS=3 and GAP_CYC=4.
- Reset, then play_p at cycle 10 -> state=GAP for cycles 11-14; state=PLAY and start_p=1 at cycle 15 only; song_idx=0; playing=1 from cycle 15.
- In PLAY, next_p three times, each spaced 10 cycles -> song_idx 1, 2, 0 (wrap); each press gives 4 GAP cycles then one start_p. prev_p from idx 0 -> idx 2.
- In PLAY, play_p -> PAUSE, playing=0; play_p again -> PLAY immediately, start_p stays 0, song_idx unchanged.
- In PLAY at idx 2, song_done -> GAP then PLAY at idx 0 with start_p. With PLAY_CTRL_REPEAT_ONE_EN defined, idx stays 2.
- In GAP at counter 2: next_p and prev_p in the same cycle -> only next acts (idx+1) and the counter reloads to 4. stop_p together with next_p -> STOP, idx unchanged, no start_p ever.
- Assert rst_n low asynchronously mid-GAP, between clock edges -> outputs reset immediately; after release, no start_p without a new play_p.

Source files
------------

// File: rtl/play_ctrl.sv
// rtl/play_ctrl.sv - player control FSM: song index, play state, gapped start pulse
// Optional PLAY_CTRL_REPEAT_ONE_EN: song_done in PLAY replays the same song.
module play_ctrl #(
    parameter int NUM_SONGS = 4,
    parameter int IDX_W     = 2,
    parameter int GAP_CYC   = 1000,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             play_p,
    input  logic             next_p,
    input  logic             prev_p,
    input  logic             stop_p,
    input  logic             song_done,
    output logic [IDX_W-1:0] song_idx,
    output logic [1:0]       state,
    output logic             playing,
    output logic             start_p
);

    localparam logic [1:0] S_STOP  = 2'd0;
    localparam logic [1:0] S_GAP   = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SONGS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] idx_prev;
    logic [IDX_W-1:0] idx_done;

    always_comb begin
        idx_next = (song_idx == LAST_IDX) ? '0 : song_idx + 1'b1;
        idx_prev = (song_idx == '0) ? LAST_IDX : song_idx - 1'b1;
`ifdef PLAY_CTRL_REPEAT_ONE_EN
        idx_done = song_idx;
`else
        idx_done = idx_next;
`endif
    end

    assign playing = (state == S_PLAY);

    // Each branch chain follows event priority: stop > next > prev > song_done > play.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_STOP;
            song_idx <= '0;
            cnt      <= '0;
            start_p  <= 1'b0;
        end else begin
            start_p <= 1'b0;
            case (state)
                S_STOP: begin
                    if (stop_p) begin
                        state <= S_STOP;
                    end else if (next_p) begin
                        song_idx <= idx_next;
                    end else if (prev_p) begin
                        song_idx <= idx_prev;
                    end else if (song_done) begin
                        state <= S_STOP;
                    end else if (play_p) begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (stop_p) begin
                        state <= S_STOP;
                        cnt   <= '0;
                    end else if (next_p) begin
                        song_idx <= idx_next;
                        cnt      <= GAP_LOAD;
                    end else if (prev_p) begin
                        song_idx <= idx_prev;
                        cnt      <= GAP_LOAD;
                    end else if (cnt == CNT_W'(1)) begin
                        state   <= S_PLAY;
                        start_p <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PLAY: begin
                    if (stop_p) begin
                        state <= S_STOP;
                    end else if (next_p) begin
                        song_idx <= idx_next;
                        state    <= S_GAP;
                        cnt      <= GAP_LOAD;
                    end else if (prev_p) begin
                        song_idx <= idx_prev;
                        state    <= S_GAP;
                        cnt      <= GAP_LOAD;
                    end else if (song_done) begin
                        song_idx <= idx_done;
                        state    <= S_GAP;
                        cnt      <= GAP_LOAD;
                    end else if (play_p) begin
                        state <= S_PAUSE;
                    end
                end
                default: begin
                    if (stop_p) begin
                        state <= S_STOP;
                    end else if (next_p) begin
                        song_idx <= idx_next;
                        state    <= S_GAP;
                        cnt      <= GAP_LOAD;
                    end else if (prev_p) begin
                        song_idx <= idx_prev;
                        state    <= S_GAP;
                        cnt      <= GAP_LOAD;
                    end else if (song_done) begin
                        state <= S_PAUSE;
                    end else if (play_p) begin
                        state <= S_PLAY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_play_ctrl.sv
// tb/tb_play_ctrl.sv - directed bench for play_ctrl with start_p scoreboard
module tb_play_ctrl;

    localparam int NUM_SONGS = 3;
    localparam int IDX_W     = 2;
    localparam int GAP_CYC   = 4;
    localparam int CNT_W     = 3;

    localparam logic [4:0] E_PLAY = 5'b00001;
    localparam logic [4:0] E_DONE = 5'b00010;
    localparam logic [4:0] E_PREV = 5'b00100;
    localparam logic [4:0] E_NEXT = 5'b01000;
    localparam logic [4:0] E_STOP = 5'b10000;

    logic             clk;
    logic             rst_n;
    logic             play_p, next_p, prev_p, stop_p, song_done;
    logic [IDX_W-1:0] song_idx;
    logic [1:0]       state;
    logic             playing;
    logic             start_p;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int exp_done_idx;

    play_ctrl #(
        .NUM_SONGS(NUM_SONGS),
        .IDX_W    (IDX_W),
        .GAP_CYC  (GAP_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .play_p   (play_p),
        .next_p   (next_p),
        .prev_p   (prev_p),
        .stop_p   (stop_p),
        .song_done(song_done),
        .song_idx (song_idx),
        .state    (state),
        .playing  (playing),
        .start_p  (start_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] ev);
        {stop_p, next_p, prev_p, song_done, play_p} = ev;
        tick();
        {stop_p, next_p, prev_p, song_done, play_p} = 5'b0;
    endtask

    // Called right after the edge that entered (or reloaded) GAP.
    task automatic wait_gap(input string tag);
        for (int k = 0; k < GAP_CYC - 1; k++) begin
            tick();
            chk({tag, "_gap_state"}, state, 1);
            chk({tag, "_gap_start"}, start_p, 0);
            chk({tag, "_gap_playing"}, playing, 0);
        end
        tick();
        chk({tag, "_play_state"}, state, 2);
        chk({tag, "_play_start"}, start_p, 1);
        chk({tag, "_play_playing"}, playing, 1);
        tick();
        chk({tag, "_start_drop"}, start_p, 0);
    endtask

    // Scoreboard: every start_p must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n && start_p) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_start observed=1 expected=0");
            end
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                assert (song_idx === IDX_W'(e)) else begin
                    n_fail++;
                    $error("FAIL sb_start_idx observed=%0d expected=%0d", song_idx, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {stop_p, next_p, prev_p, song_done, play_p} = 5'b0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_idx", song_idx, 0);
        chk("rst_playing", playing, 0);
        chk("rst_start", start_p, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();

        press(E_PLAY);
        exp_q.push_back(0);
        chk("play_enter_gap", state, 1);
        wait_gap("first_play");
        chk("first_play_idx", song_idx, 0);

        for (int n = 1; n <= 3; n++) begin
            press(E_NEXT);
            chk("next_idx", song_idx, n % NUM_SONGS);
            chk("next_gap", state, 1);
            exp_q.push_back(n % NUM_SONGS);
            wait_gap("next");
            for (int i = 0; i < 4; i++) tick();
        end

        press(E_PREV);
        chk("prev_wrap_idx", song_idx, 2);
        exp_q.push_back(2);
        wait_gap("prev");

        press(E_PLAY);
        chk("pause_state", state, 3);
        chk("pause_playing", playing, 0);
        tick();
        tick();
        chk("pause_hold", state, 3);
        press(E_PLAY);
        chk("resume_state", state, 2);
        chk("resume_start", start_p, 0);
        chk("resume_idx", song_idx, 2);
        tick();
        chk("resume_start_after", start_p, 0);

`ifdef PLAY_CTRL_REPEAT_ONE_EN
        exp_done_idx = 2;
`else
        exp_done_idx = 0;
`endif
        press(E_DONE);
        chk("done_gap", state, 1);
        chk("done_idx", song_idx, exp_done_idx);
        exp_q.push_back(exp_done_idx);
        wait_gap("done");

        press(E_NEXT);
        tick();
        tick();
        press(E_NEXT | E_PREV);
        chk("prio_next_idx", song_idx, (exp_done_idx + 2) % NUM_SONGS);
        chk("prio_gap", state, 1);
        exp_q.push_back((exp_done_idx + 2) % NUM_SONGS);
        wait_gap("reload");

        press(E_NEXT);
        chk("pre_stop_idx", song_idx, exp_done_idx);
        tick();
        tick();
        press(E_STOP | E_NEXT);
        chk("stop_state", state, 0);
        chk("stop_idx", song_idx, exp_done_idx);
        chk("stop_playing", playing, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("stop_stays", state, 0);

        press(E_NEXT);
        chk("stop_next_state", state, 0);
        chk("stop_next_idx", song_idx, (exp_done_idx + 1) % NUM_SONGS);

        press(E_PLAY);
        chk("rst_pre_gap", state, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_idx", song_idx, 0);
        chk("async_rst_start", start_p, 0);
        chk("async_rst_playing", playing, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_state", state, 0);
        chk("post_rst_start", start_p, 0);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
